load_store_unit: RTL and testbench

Memory-stage sequencer of the hypiu core, directly upstream of `data_ram_access`. It accepts one load/store request at a time from execute over a valid/ready handshake and drives `data_ram_access` with registered `addr`, `ebit`, `write_data` and `rw_n`. It samples `read_data` and returns load data or a store acknowledge over a valid/ready response handshake. Byte loads (zero- or sign-extended) and byte stores are built on the 16-bit word RAM, with byte stores done as read-modify-write.

---
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage sequencer of the hypiu core. It sits directly
// upstream of data_ram_access. It accepts one load/store request at a time,
// drives registered RAM address/bank/data/rw_n, and returns load data or a
// store acknowledge over a valid/ready response handshake.
//
// Build option: define LSU_BYTE_ACCESS_EN to enable byte loads (zero/sign
// extended) and byte stores (read-modify-write). When it is undefined,
// i_req_byte/i_req_hi/i_req_signed are ignored and every access is a word access.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_we                1 = store, 0 = load
//   i_req_byte/i_req_hi     byte access / upper byte lane select
//   i_req_signed            sign-extend byte loads
//   i_req_addr[16:0]        bit 16 = ebit bank select, [15:0] word address
//   i_req_wdata[15:0]       store data (byte stores use [7:0])
//   o_resp_valid/i_resp_ready/o_resp_rdata  response handshake, 0 for stores
//   o_mem_addr, o_mem_ebit, o_mem_write_data, o_mem_rw_n  registered RAM controls
//   i_mem_read_data         asynchronous RAM read data
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_byte,
    input  logic        i_req_hi,
    input  logic        i_req_signed,
    input  logic [16:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [15:0] o_resp_rdata,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_ebit,
    output logic [15:0] o_mem_write_data,
    output logic        o_mem_rw_n,
    input  logic [15:0] i_mem_read_data
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_ebit;
    logic [DATA_W-1:0]   r_mem_write_data;
    logic                r_mem_rw_n;
    logic                r_we;

    logic                w_accept;
    logic                w_req_byte;
    logic                w_byte_r;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_resp_data;
    logic                w_req_ready_d;
    logic                w_resp_valid_d;
    logic                w_mem_rw_n_d;

`ifdef LSU_BYTE_ACCESS_EN
    logic                r_byte;
    logic                r_hi;
    logic                r_signed;
    logic [BYTE_W-1:0]   r_wbyte;
    logic [BYTE_W-1:0]   w_lane;
    logic [DATA_W-1:0]   w_merge;

    assign w_req_byte = i_req_byte;
    assign w_byte_r   = r_byte;

    // Selected byte lane of the word currently on the RAM read port.
    assign w_lane = r_hi ? i_mem_read_data[15:8] : i_mem_read_data[7:0];

    // Load result: full word, or the lane zero/sign extended.
    assign w_load_data = !r_byte  ? i_mem_read_data :
                         r_signed ? {{BYTE_W{w_lane[BYTE_W-1]}}, w_lane} :
                                    {BYTE_W'(0), w_lane};

    // Byte store: new byte replaces the selected lane of the old word.
    assign w_merge = r_hi ? {r_wbyte, i_mem_read_data[7:0]}
                          : {i_mem_read_data[15:8], r_wbyte};
`else
    logic                w_unused_byte_ctrl;

    assign w_req_byte         = 1'b0;
    assign w_byte_r           = 1'b0;
    assign w_load_data        = i_mem_read_data;
    assign w_unused_byte_ctrl = ^{i_req_byte, i_req_hi, i_req_signed};
`endif

    assign w_accept    = r_req_ready & i_req_valid;
    assign w_resp_data = r_we ? DATA_W'(0) : w_load_data;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and next values of the state-derived output registers.
    always_comb begin
        w_next_state   = r_state;
        w_req_ready_d  = 1'b0;
        w_resp_valid_d = 1'b0;
        w_mem_rw_n_d   = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Word stores write immediately; loads and byte stores read first.
                    w_next_state = (i_req_we && !w_req_byte) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                w_next_state = (r_we && w_byte_r) ? S_WR : S_RESP;
            end
            S_WR: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (r_resp_valid && i_resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        w_req_ready_d  = (w_next_state == S_IDLE);
        w_resp_valid_d = (w_next_state == S_RESP);
        w_mem_rw_n_d   = (w_next_state != S_WR);
    end

    // Output and request-field registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= '0;
            r_mem_addr       <= '0;
            r_mem_ebit       <= 1'b0;
            r_mem_write_data <= '0;
            r_mem_rw_n       <= 1'b1;
            r_we             <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_d;
            r_resp_valid <= w_resp_valid_d;
            r_mem_rw_n   <= w_mem_rw_n_d;

            if (w_accept) begin
                r_mem_addr <= i_req_addr[ADDR_W-1:0];
                r_mem_ebit <= i_req_addr[ADDR_W];
                r_we       <= i_req_we;
                if (i_req_we) begin
                    r_mem_write_data <= i_req_wdata;
                end
            end

            // Read data is taken at the end of RD; stores respond with 0.
            if (r_state == S_RD) begin
                r_resp_rdata <= w_resp_data;
`ifdef LSU_BYTE_ACCESS_EN
                if (r_we) begin
                    r_mem_write_data <= w_merge;
                end
`endif
            end

            if (r_state == S_WR) begin
                r_resp_rdata <= '0;
            end
        end
    end

`ifdef LSU_BYTE_ACCESS_EN
    // Byte-access request fields, captured at accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_byte   <= 1'b0;
            r_hi     <= 1'b0;
            r_signed <= 1'b0;
            r_wbyte  <= '0;
        end else if (w_accept) begin
            r_byte   <= i_req_byte;
            r_hi     <= i_req_hi;
            r_signed <= i_req_signed;
            r_wbyte  <= i_req_wdata[BYTE_W-1:0];
        end
    end
`endif

    assign o_req_ready      = r_req_ready;
    assign o_resp_valid     = r_resp_valid;
    assign o_resp_rdata     = r_resp_rdata;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_ebit       = r_mem_ebit;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_rw_n       = r_mem_rw_n;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a clock-gated word RAM model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic        req_hi;
    logic        req_signed;
    logic [16:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr;
    logic        mem_ebit;
    logic [15:0] mem_write_data;
    logic        mem_rw_n;
    logic [15:0] mem_read_data;

    logic [15:0] ram [0:511];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    bit in_resp     = 1'b0;
    logic [15:0] held_rdata = '0;

    logic [15:0] exp_rdata_q [$];
    int          exp_lat_q   [$];
    int          exp_acc_q   [$];
    logic [16:0] exp_waddr_q [$];
    logic [15:0] exp_wdata_q [$];

    load_store_unit dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_we         (req_we),
        .i_req_byte       (req_byte),
        .i_req_hi         (req_hi),
        .i_req_signed     (req_signed),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_resp_valid     (resp_valid),
        .i_resp_ready     (resp_ready),
        .o_resp_rdata     (resp_rdata),
        .o_mem_addr       (mem_addr),
        .o_mem_ebit       (mem_ebit),
        .o_mem_write_data (mem_write_data),
        .o_mem_rw_n       (mem_rw_n),
        .i_mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = ram[{mem_ebit, mem_addr[7:0]}];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // RAM model: writes during the clock-low half when rw_n is low; every write is scored.
    always @(negedge clk) begin
        if (mem_rw_n === 1'b0) begin
            ram[{mem_ebit, mem_addr[7:0]}] = mem_write_data;
            if (exp_waddr_q.size() == 0) begin
                check("unexpected_write", {mem_ebit, mem_addr}, 32'h0);
            end else begin
                check("write_addr", {mem_ebit, mem_addr}, exp_waddr_q.pop_front());
                check("write_data", mem_write_data, exp_wdata_q.pop_front());
            end
        end
    end

    // Response monitor: score first cycle of each response, then hold stability.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (!in_resp) begin
                if (exp_rdata_q.size() == 0) begin
                    check("unexpected_resp", resp_rdata, 32'h0);
                end else begin
                    check("resp_rdata", resp_rdata, exp_rdata_q.pop_front());
                    check("resp_latency", cyc + 1 - exp_acc_q.pop_front(), exp_lat_q.pop_front());
                end
                held_rdata = resp_rdata;
                in_resp = 1'b1;
            end else begin
                check("resp_stable", resp_rdata, held_rdata);
            end
            if (resp_ready) begin
                in_resp = 1'b0;
                done_cnt++;
            end
        end
    end

    // Issue one request from the phase just after a rising edge; returns at the same phase.
    task automatic do_req(input logic we, input logic byt, input logic hi, input logic sgn,
                          input logic [16:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rd, input int exp_lat,
                          input logic exp_wr, input logic [15:0] exp_wd, input int hold);
        int target;
        int k;
        req_valid  = 1'b1;
        req_we     = we;
        req_byte   = byt;
        req_hi     = hi;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        @(negedge clk);
        check("req_ready_issue", req_ready, 1);
        exp_acc_q.push_back(cyc + 1);
        exp_rdata_q.push_back(exp_rd);
        exp_lat_q.push_back(exp_lat);
        if (exp_wr) begin
            exp_waddr_q.push_back(addr);
            exp_wdata_q.push_back(exp_wd);
        end
        target = done_cnt + 1;
        @(posedge clk); #1;
        // Scramble request fields: the unit must not rely on them after accept.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_byte   = ~byt;
        req_hi     = ~hi;
        req_signed = ~sgn;
        req_addr   = 17'h1_5A5A;
        req_wdata  = 16'hDEAD;
        if (hold > 0) begin
            k = 0;
            while (resp_valid !== 1'b1 && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            for (int i = 0; i < hold; i++) begin
                check("req_ready_backpressure", req_ready, 0);
                check("resp_valid_backpressure", resp_valid, 1);
                req_valid = (i == 2);
                req_we    = 1'b1;
                req_byte  = 1'b0;
                req_addr  = addr;
                req_wdata = 16'h5555;
                @(posedge clk); #1;
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        k = 0;
        while (done_cnt < target && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt < target) check("resp_timeout", 0, 1);
        resp_ready = 1'b1;
    endtask

    // Store aborted by reset on the edge that would enter WR.
    task automatic reset_store(input logic [16:0] addr, input logic [15:0] old);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_byte   = 1'b1;
        req_hi     = 1'b1;
        req_signed = 1'b0;
        req_addr   = addr;
        req_wdata  = 16'h00CD;
`ifdef LSU_BYTE_ACCESS_EN
        @(posedge clk); #1;
        req_valid = 1'b0;
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_store_rw_n", mem_rw_n, 1);
        check("rst_store_resp_valid", resp_valid, 0);
        check("rst_store_req_ready", req_ready, 1);
        @(posedge clk); #1;
        check("rst_store_ram", ram[{addr[16], addr[7:0]}], old);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_hi     = 1'b0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_rw_n", mem_rw_n, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_ebit", mem_ebit, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        @(posedge clk); #1;

        //     we    byte  hi    sgn   addr        wdata     exp_rd    lat wr    exp_wd    hold
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 17'h1_0123, 16'hBEEF, 16'h0000, 2, 1'b1, 16'hBEEF, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h1_0123, 16'h0000, 16'hBEEF, 2, 1'b0, 16'h0000, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0123, 16'h0000, 16'h0000, 2, 1'b0, 16'h0000, 0);
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 17'h0_0040, 16'h12F0, 16'h0000, 2, 1'b1, 16'h12F0, 0);
`ifdef LSU_BYTE_ACCESS_EN
        do_req(1'b0, 1'b1, 1'b0, 1'b1, 17'h0_0040, 16'h0000, 16'hFFF0, 2, 1'b0, 16'h0000, 0);
        do_req(1'b0, 1'b1, 1'b0, 1'b0, 17'h0_0040, 16'h0000, 16'h00F0, 2, 1'b0, 16'h0000, 0);
        do_req(1'b0, 1'b1, 1'b1, 1'b1, 17'h0_0040, 16'h0000, 16'h0012, 2, 1'b0, 16'h0000, 0);
        do_req(1'b0, 1'b1, 1'b1, 1'b0, 17'h0_0040, 16'h0000, 16'h0012, 2, 1'b0, 16'h0000, 0);
        do_req(1'b1, 1'b1, 1'b1, 1'b0, 17'h0_0040, 16'h00AB, 16'h0000, 3, 1'b1, 16'hABF0, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0040, 16'h0000, 16'hABF0, 2, 1'b0, 16'h0000, 0);
        do_req(1'b1, 1'b1, 1'b0, 1'b0, 17'h0_0040, 16'h1234, 16'h0000, 3, 1'b1, 16'hAB34, 0);
        do_req(1'b0, 1'b1, 1'b1, 1'b1, 17'h0_0040, 16'h0000, 16'hFFAB, 2, 1'b0, 16'h0000, 0);
        reset_store(17'h0_0040, 16'hAB34);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0040, 16'h0000, 16'hAB34, 2, 1'b0, 16'h0000, 0);
`else
        do_req(1'b0, 1'b1, 1'b1, 1'b1, 17'h0_0040, 16'h0000, 16'h12F0, 2, 1'b0, 16'h0000, 0);
        do_req(1'b1, 1'b1, 1'b1, 1'b0, 17'h0_0040, 16'h00AB, 16'h0000, 2, 1'b1, 16'h00AB, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0040, 16'h0000, 16'h00AB, 2, 1'b0, 16'h0000, 0);
        reset_store(17'h0_0040, 16'h00AB);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h0_0040, 16'h0000, 16'h00AB, 2, 1'b0, 16'h0000, 0);
`endif
        // Load held under backpressure for 5 cycles with a stray request pulse.
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h1_0123, 16'h0000, 16'hBEEF, 2, 1'b0, 16'h0000, 5);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 17'h1_0123, 16'h0000, 16'hBEEF, 2, 1'b0, 16'h0000, 0);

        repeat (4) @(posedge clk);
        check("pending_responses", exp_rdata_q.size(), 0);
        check("pending_writes", exp_waddr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
